bit_scan_serializer: RTL and testbench

Serializes a multi-bit request vector into a stream of one-hot beats, one per set bit, in ascending bit order (lowest index first). A vector is accepted on a valid/ready input port, held internally, and emitted bit by bit on a valid/ready output port with a last flag on the final beat. It sits downstream of request-collecting logic and feeds per-request consumers such as arbiters, dispatchers and interrupt servicers. Within the operations library it is the sequential, iterating counterpart to the combinational priority one-hot extractor.

---
 rtl/bit_scan_serializer.sv | 111 +++++++++++
 tb/tb_bit_scan_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_serializer.sv
// Serializes a request vector into one-hot beats, lowest set bit first, with a last flag.
// Define BIT_SCAN_SERIALIZER_INDEX_EN to add the binary output_index port.
module bit_scan_serializer #(
  parameter int WIDTH = 8
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
  , localparam int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_one_hot,
  output logic             output_last,
  output logic             output_valid,
  input  logic             output_ready
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
  , output logic [INDEX_WIDTH-1:0] output_index
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] lowest;
  logic             rest_empty;
  logic             scanning;

  // Two's-complement trick isolates the lowest set bit of the pending mask.
  assign lowest     = pending & ((~pending) + WIDTH'(1'b1));
  assign rest_empty = ((pending & ~lowest) == '0);
  assign scanning   = (state == SCAN) && !reset;

`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
  function automatic logic [INDEX_WIDTH-1:0] encode(input logic [WIDTH-1:0] one_hot);
    logic [INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (one_hot[i]) begin
        idx = idx | INDEX_WIDTH'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction
`endif

  // Output decode from the pending register; everything forced to zero outside SCAN or in reset.
  always_comb begin
    output_valid   = 1'b0;
    output_one_hot = '0;
    output_last    = 1'b0;
    input_ready    = 1'b0;
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
    output_index   = '0;
`endif
    if (reset) begin
      input_ready = 1'b0;
    end else if (scanning) begin
      output_valid   = 1'b1;
      output_one_hot = lowest;
      output_last    = rest_empty;
      input_ready    = output_ready && rest_empty;
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
      output_index   = encode(lowest);
`endif
    end else begin
      input_ready = 1'b1;
    end
  end

  // State and pending mask; a new vector is taken on the edge the last beat leaves.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (input_valid && (input_data != '0)) begin
            pending <= input_data;
            state   <= SCAN;
          end else begin
            pending <= '0;
            state   <= IDLE;
          end
        end
        SCAN: begin
          if (!output_ready) begin
            pending <= pending;
          end else if (!rest_empty) begin
            pending <= pending & ~lowest;
          end else if (input_valid && (input_data != '0)) begin
            pending <= input_data;
          end else begin
            pending <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Self-checking bench: queue-of-indices reference model checked every cycle, plus directed literal checks.
module tb_bit_scan_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] input_data = 8'h00;
  logic       input_valid = 1'b0;
  logic       input_ready;
  logic [7:0] output_one_hot;
  logic       output_last;
  logic       output_valid;
  logic       output_ready = 1'b0;

  logic       i1_data = 1'b0;
  logic       i1_valid = 1'b0;
  logic       i1_ready;
  logic       o1_one_hot;
  logic       o1_last;
  logic       o1_valid;
  logic       o1_ready = 1'b0;

`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
  logic [2:0] output_index;
  logic [0:0] o1_index;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bit_scan_serializer #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
    .output_one_hot(output_one_hot), .output_last(output_last),
    .output_valid(output_valid), .output_ready(output_ready)
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
    , .output_index(output_index)
`endif
  );

  bit_scan_serializer #(.WIDTH(1)) dut1 (
    .clock(clock), .reset(reset),
    .input_data(i1_data), .input_valid(i1_valid), .input_ready(i1_ready),
    .output_one_hot(o1_one_hot), .output_last(o1_last),
    .output_valid(o1_valid), .output_ready(o1_ready)
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
    , .output_index(o1_index)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reference model: the bit positions still to be emitted for the vector in flight.
  int q[$];

  always @(negedge clock) begin
    logic       e_valid;
    logic       e_last;
    logic       e_ready;
    logic [7:0] e_oh;
    int         e_idx;
    e_valid = !reset && (q.size() > 0);
    e_last  = e_valid && (q.size() == 1);
    e_oh    = e_valid ? (8'h01 << q[0]) : 8'h00;
    e_idx   = e_valid ? q[0] : 0;
    e_ready = !reset && ((q.size() == 0) || (output_ready && q.size() == 1));
    check("model_valid", {31'd0, output_valid}, {31'd0, e_valid});
    check("model_one_hot", {24'd0, output_one_hot}, {24'd0, e_oh});
    check("model_last", {31'd0, output_last}, {31'd0, e_last});
    check("model_ready", {31'd0, input_ready}, {31'd0, e_ready});
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
    check("model_index", {29'd0, output_index}, e_idx);
`endif
    if (reset) begin
      q.delete();
    end else begin
      if (e_valid && output_ready) void'(q.pop_front());
      if (e_ready && input_valid) begin
        for (int b = 0; b < 8; b++) if (input_data[b]) q.push_back(b);
      end
    end
  end

  logic [7:0] exp_b[4];

  initial begin
    exp_b = '{8'h02, 8'h04, 8'h10, 8'h80};
    cyc(); cyc();
    check("reset_valid", {31'd0, output_valid}, 32'd0);
    check("reset_ready", {31'd0, input_ready}, 32'd0);
    check("reset_one_hot", {24'd0, output_one_hot}, 32'd0);

    // Basic serialization of 0x96
    reset = 1'b0; input_data = 8'h96; input_valid = 1'b1; output_ready = 1'b1;
    #2 check("idle_ready", {31'd0, input_ready}, 32'd1);
    cyc(); input_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("basic_beat", {24'd0, output_one_hot}, {24'd0, exp_b[k]});
      check("basic_last", {31'd0, output_last}, (k == 3) ? 32'd1 : 32'd0);
      check("basic_ready", {31'd0, input_ready}, (k == 3) ? 32'd1 : 32'd0);
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
      check("basic_index", {29'd0, output_index}, (k == 0) ? 32'd1 : (k == 1) ? 32'd2 : (k == 2) ? 32'd4 : 32'd7);
`endif
      cyc();
    end
    #2 check("basic_done", {31'd0, output_valid}, 32'd0);

    // Backpressure on 0x0C
    input_data = 8'h0C; input_valid = 1'b1; output_ready = 1'b0;
    cyc(); input_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("bp_hold", {24'd0, output_one_hot}, 32'h04);
      check("bp_last", {31'd0, output_last}, 32'd0);
      check("bp_valid", {31'd0, output_valid}, 32'd1);
      cyc();
    end
    output_ready = 1'b1;
    #2 check("bp_beat0", {24'd0, output_one_hot}, 32'h04);
    cyc();
    #2 check("bp_beat1", {24'd0, output_one_hot}, 32'h08);
    check("bp_last1", {31'd0, output_last}, 32'd1);
    cyc();

    // Zero vector is swallowed
    input_data = 8'h00; input_valid = 1'b1;
    cyc(); input_valid = 1'b0;
    #2 check("zero_valid", {31'd0, output_valid}, 32'd0);
    check("zero_ready", {31'd0, input_ready}, 32'd1);

    // Back-to-back 0x01 then 0x80
    input_data = 8'h01; input_valid = 1'b1;
    cyc(); input_data = 8'h80;
    #2 check("b2b_first", {24'd0, output_one_hot}, 32'h01);
    check("b2b_first_last", {31'd0, output_last}, 32'd1);
    check("b2b_ready", {31'd0, input_ready}, 32'd1);
    cyc(); input_valid = 1'b0;
    #2 check("b2b_second", {24'd0, output_one_hot}, 32'h80);
    check("b2b_second_valid", {31'd0, output_valid}, 32'd1);
    cyc();
    #2 check("b2b_done", {31'd0, output_valid}, 32'd0);

    // Reset after two beats of 0xFF
    input_data = 8'hFF; input_valid = 1'b1;
    cyc(); input_valid = 1'b0;
    #2 check("rst_beat0", {24'd0, output_one_hot}, 32'h01);
    cyc();
    #2 check("rst_beat1", {24'd0, output_one_hot}, 32'h02);
    cyc();
    reset = 1'b1;
    #2 check("rst_valid", {31'd0, output_valid}, 32'd0);
    check("rst_ready", {31'd0, input_ready}, 32'd0);
    cyc(); reset = 1'b0;
    #2 check("rst_after_valid", {31'd0, output_valid}, 32'd0);
    check("rst_after_ready", {31'd0, input_ready}, 32'd1);
    cyc();
    #2 check("rst_no_residue", {31'd0, output_valid}, 32'd0);

    // All ones
    input_data = 8'hFF; input_valid = 1'b1;
    cyc(); input_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #2;
      check("ones_beat", {24'd0, output_one_hot}, 32'd1 << k);
      check("ones_last", {31'd0, output_last}, (k == 7) ? 32'd1 : 32'd0);
      cyc();
    end

    // WIDTH=1 instance
    i1_data = 1'b1; i1_valid = 1'b1; o1_ready = 1'b1;
    cyc(); i1_valid = 1'b0;
    #2 check("w1_valid", {31'd0, o1_valid}, 32'd1);
    check("w1_one_hot", {31'd0, o1_one_hot}, 32'd1);
    check("w1_last", {31'd0, o1_last}, 32'd1);
`ifdef BIT_SCAN_SERIALIZER_INDEX_EN
    check("w1_index", {31'd0, o1_index}, 32'd0);
`endif
    cyc();
    #2 check("w1_done", {31'd0, o1_valid}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      input_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: input_data = 8'h00;
        1: input_data = 8'h01 << $urandom_range(0, 7);
        default: input_data = 8'($urandom);
      endcase
      output_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    reset = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
    for (int n = 0; n < 12; n++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
